// File: rtl/sprite_plotter.sv
// Erases each sprite slot at its previous anchor and redraws it at the latched anchor,
// emitting one 13-pixel glyph per pass to a VGA pixel writer.
module sprite_plotter #(
    parameter int N_SPRITES = 6,
    parameter int X_MAX     = 159,
    parameter int Y_MAX     = 119
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [N_SPRITES-1:0]   active,
    input  logic [8*N_SPRITES-1:0] pos_x,
    input  logic [7*N_SPRITES-1:0] pos_y,
    input  logic [2:0]             draw_colour,
    output logic [7:0]             x_out,
    output logic [6:0]             y_out,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    localparam int SW = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(N_SPRITES - 1);
    localparam logic signed [9:0] XM = 10'(X_MAX);
    localparam logic signed [8:0] YM = 9'(Y_MAX);

    typedef enum logic [2:0] {IDLE, SELECT, ERASE, DRAW, DONE} state_t;

    state_t               state, nstate;
    logic [SW-1:0]        slot, nslot;
    logic [3:0]           k, nk;
    logic                 accept, slot_end;
    logic [N_SPRITES-1:0] act_l, prev_valid;
    logic [7:0]           lat_x  [N_SPRITES];
    logic [6:0]           lat_y  [N_SPRITES];
    logic [7:0]           prev_x [N_SPRITES];
    logic [6:0]           prev_y [N_SPRITES];

    logic                 is_pix, pix_on;
    logic [7:0]           ax;
    logic [6:0]           ay;
    logic signed [3:0]    dx, dy;
    logic signed [9:0]    sx;
    logic signed [8:0]    sy;

    function automatic logic signed [3:0] dx_of(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1:   dx_of = 4'sd0;
            4'd2:         dx_of = -4'sd1;
            4'd3:         dx_of = -4'sd2;
            4'd4:         dx_of = -4'sd3;
            4'd5:         dx_of = -4'sd4;
            4'd6:         dx_of = -4'sd5;
            4'd7, 4'd8:   dx_of = -4'sd3;
            4'd9, 4'd10:  dx_of = -4'sd4;
            default:      dx_of = -4'sd5;
        endcase
    endfunction

    function automatic logic signed [3:0] dy_of(input logic [3:0] idx);
        case (idx)
            4'd1, 4'd7: dy_of = 4'sd1;
            4'd8:       dy_of = -4'sd1;
            4'd9:       dy_of = 4'sd2;
            4'd10:      dy_of = -4'sd2;
            4'd11:      dy_of = 4'sd3;
            4'd12:      dy_of = -4'sd3;
            default:    dy_of = 4'sd0;
        endcase
    endfunction

    always_comb begin
        nstate   = state;
        nslot    = slot;
        nk       = k;
        accept   = 1'b0;
        slot_end = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    nstate = SELECT;
                    nslot  = '0;
                end
            end
            SELECT: begin
                nk = 4'd0;
                if (prev_valid[slot])  nstate = ERASE;
                else if (act_l[slot])  nstate = DRAW;
                else                   slot_end = 1'b1;
            end
            ERASE: begin
                if (k == 4'd12) begin
                    nk = 4'd0;
                    if (act_l[slot]) nstate = DRAW;
                    else             slot_end = 1'b1;
                end else begin
                    nk = k + 4'd1;
                end
            end
            DRAW: begin
                if (k == 4'd12) slot_end = 1'b1;
                else            nk = k + 4'd1;
            end
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
        if (slot_end) begin
            if (slot == LAST_SLOT) begin
                nstate = DONE;
            end else begin
                nstate = SELECT;
                nslot  = slot + 1'b1;
            end
        end
    end

    // Pixel for the upcoming cycle, so the registered outputs line up with the state
    always_comb begin
        is_pix = (nstate == ERASE) || (nstate == DRAW);
        ax     = (nstate == ERASE) ? prev_x[nslot] : lat_x[nslot];
        ay     = (nstate == ERASE) ? prev_y[nslot] : lat_y[nslot];
        dx     = dx_of(nk);
        dy     = dy_of(nk);
        sx     = $signed({2'b00, ax}) + {{6{dx[3]}}, dx};
        sy     = $signed({2'b00, ay}) + {{5{dy[3]}}, dy};
        pix_on = is_pix && (sx >= 10'sd0) && (sx <= XM) && (sy >= 9'sd0) && (sy <= YM);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            slot       <= '0;
            k          <= 4'd0;
            act_l      <= '0;
            prev_valid <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            x_out      <= 8'd0;
            y_out      <= 7'd0;
            colour     <= 3'd0;
        end else begin
            state <= nstate;
            slot  <= nslot;
            k     <= nk;
            if (accept)   act_l <= active;
            if (slot_end) prev_valid[slot] <= act_l[slot];
            plot   <= pix_on;
            busy   <= (nstate == SELECT) || (nstate == ERASE) || (nstate == DRAW);
            done   <= (nstate == DONE);
            x_out  <= is_pix ? sx[7:0] : 8'd0;
            y_out  <= is_pix ? sy[6:0] : 7'd0;
            colour <= (nstate == DRAW) ? draw_colour : 3'd0;
        end
    end

    // Anchors are plain data; only prev_valid decides whether they are used
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                lat_x[i] <= pos_x[8*i +: 8];
                lat_y[i] <= pos_y[7*i +: 7];
            end
        end
        if (slot_end) begin
            prev_x[slot] <= lat_x[slot];
            prev_y[slot] <= lat_y[slot];
        end
    end

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter with two slots: expected per-cycle outputs are queued
// at stimulus time and popped by a monitor whenever busy or done is high.
module tb_sprite_plotter;

    localparam int N = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] active;
    logic [15:0]  pos_x;
    logic [13:0]  pos_y;
    logic [2:0]   draw_colour;
    logic [7:0]   x_out;
    logic [6:0]   y_out;
    logic [2:0]   colour;
    logic         plot, busy, done;

    sprite_plotter #(.N_SPRITES(N), .X_MAX(159), .Y_MAX(119)) dut (
        .clock(clock), .reset(reset), .start(start), .active(active),
        .pos_x(pos_x), .pos_y(pos_y), .draw_colour(draw_colour),
        .x_out(x_out), .y_out(y_out), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       chk_pix;
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0;
    int   frames_done = 0, cyc = 0, last_len = 0;
    bit   mon_en = 1'b1;

    int dxt[13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
    int dyt[13] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 2, -2, 3, -3};

    logic [1:0] mpv = 2'b00;
    int         mpx[2], mpy[2];

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic push_ctl(input logic d);
        exp_t e;
        e = '0;
        e.done = d;
        q.push_back(e);
    endtask

    task automatic push_pass(input int ax, input int ay, input logic [2:0] c);
        exp_t e;
        int sx, sy;
        for (int k = 0; k < 13; k++) begin
            sx = ax + dxt[k];
            sy = ay + dyt[k];
            e.chk_pix = 1'b1;
            e.plot    = (sx >= 0) && (sx <= 159) && (sy >= 0) && (sy <= 119);
            e.x       = sx[7:0];
            e.y       = sy[6:0];
            e.c       = c;
            e.done    = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic plan(input logic [1:0] act, input int x0, input int y0,
                        input int x1, input int y1, input logic [2:0] col);
        int nx[2], ny[2];
        nx[0] = x0; ny[0] = y0; nx[1] = x1; ny[1] = y1;
        active      = act;
        pos_x       = {8'(x1), 8'(x0)};
        pos_y       = {7'(y1), 7'(y0)};
        draw_colour = col;
        for (int i = 0; i < N; i++) begin
            push_ctl(1'b0);
            if (mpv[i]) push_pass(mpx[i], mpy[i], 3'd0);
            if (act[i]) push_pass(nx[i], ny[i], col);
            mpv[i] = act[i];
            mpx[i] = nx[i];
            mpy[i] = ny[i];
        end
        push_ctl(1'b1);
    endtask

    task automatic run_frame(input string nm, input int exp_len, input bit disturb);
        int  f0;
        bit  seen;
        f0   = frames_done;
        seen = 1'b0;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (disturb && i == 5) begin
                start  = 1'b1;
                pos_x  = ~pos_x;
                pos_y  = ~pos_y;
                active = ~active;
            end
            if (disturb && i == 6) start = 1'b0;
            @(negedge clock);
            if (frames_done != f0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done, expected done within 200 cycles", nm);
            q.delete();
        end else begin
            check({nm, "_len"}, last_len, exp_len);
        end
        repeat (4) @(negedge clock);
        check({nm, "_queue_left"}, q.size(), 0);
        check({nm, "_done_count"}, frames_done - f0, 1);
    endtask

    // Monitor: one queue entry per busy/done cycle
    always @(negedge clock) begin
        exp_t e;
        if (mon_en && !reset && (busy || done)) begin
            cyc++;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got busy=%0b done=%0b plot=%0b, expected idle",
                         busy, done, plot);
            end else begin
                e = q.pop_front();
                if (plot !== e.plot || busy !== !e.done || done !== e.done ||
                    (e.chk_pix && (x_out !== e.x || y_out !== e.y || colour !== e.c))) begin
                    fails++;
                    $display("FAIL pixel_cycle%0d: got plot=%0b busy=%0b done=%0b x=%0d y=%0d c=%0d expected plot=%0b busy=%0b done=%0b x=%0d y=%0d c=%0d",
                             cyc, plot, busy, done, x_out, y_out, colour,
                             e.plot, !e.done, e.done, e.x, e.y, e.c);
                end
            end
            if (done) begin
                last_len = cyc;
                cyc = 0;
                frames_done++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; active = '0; pos_x = '0; pos_y = '0; draw_colour = '0;
        repeat (3) @(negedge clock);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_xyc", {x_out, y_out, colour}, 0);
        reset = 1'b0;
        @(negedge clock);

        plan(2'b01, 10, 20, 0, 0, 3'd7);
        run_frame("first_draw", 16, 1'b0);
        plan(2'b01, 11, 20, 0, 0, 3'd7);
        run_frame("move", 29, 1'b0);
        plan(2'b01, 2, 1, 0, 0, 3'd3);
        run_frame("clip", 29, 1'b0);
        plan(2'b00, 0, 0, 0, 0, 3'd3);
        run_frame("erase_only", 16, 1'b0);
        plan(2'b00, 0, 0, 0, 0, 3'd3);
        run_frame("empty", 3, 1'b0);
        plan(2'b11, 50, 50, 159, 119, 3'd5);
        run_frame("restart_ignored", 29, 1'b1);

        // Reset in the middle of a draw pass: erase c2-14, draw k=6 falls on cycle 21
        mon_en = 1'b0;
        active = 2'b01; pos_x = {8'd0, 8'd30}; pos_y = {7'd0, 7'd30}; draw_colour = 3'd5;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (20) @(negedge clock);
        check("k6_plot", plot, 1);
        check("k6_x", x_out, 25);
        check("k6_y", y_out, 30);
        check("k6_colour", colour, 5);
        reset = 1'b1;
        #1;
        check("async_rst_plot", plot, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_xyc", {x_out, y_out, colour}, 0);
        @(negedge clock) reset = 1'b0;
        mpv    = 2'b00;
        mon_en = 1'b1;
        plan(2'b01, 30, 30, 0, 0, 3'd6);
        run_frame("after_reset", 16, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_plotter.md
SPRITE_PLOTTER -- requirements
Module: sprite_plotter

Interface
REQ-001 SHALL have parameter N_SPRITES, default 6: number of sprite slots plotted per frame.
REQ-002 SHALL have parameter X_MAX, default 159: largest on-screen x.
REQ-003 SHALL have parameter Y_MAX, default 119: largest on-screen y.
REQ-004 SHALL have port clock, input, 1: single clock for all logic.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: frame request, sampled only in IDLE.
REQ-007 SHALL have port active, input, N_SPRITES: per-slot draw enable.
REQ-008 SHALL have port pos_x, input, 8*N_SPRITES: slot i anchor x in bits [8i+7:8i].
REQ-009 SHALL have port pos_y, input, 7*N_SPRITES: slot i anchor y in bits [7i+6:7i].
REQ-010 SHALL have port draw_colour, input, 3: colour for draw passes.
REQ-011 SHALL have ports x_out (output, 8), y_out (output, 7), colour (output, 3) and plot (output, 1): the pixel write to the VGA adapter.
REQ-012 SHALL have port busy, output, 1: high from the cycle after start is accepted until done.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when the frame completes.

Function
REQ-014 SHALL implement states IDLE, SELECT, ERASE, DRAW, DONE.
- IDLE to SELECT on start.
- SELECT always lasts 1 cycle, with plot=0.
- SELECT to ERASE if prev_valid[i], else to DRAW if active[i], else to the next slot.
- ERASE to DRAW after 13 pixels if active[i], else to the next slot.
- DRAW to the next slot after 13 pixels.
- After the last slot, go to DONE; DONE to IDLE after 1 cycle.
REQ-015 SHALL, on accepting start, latch active, pos_x and pos_y into internal registers; input changes while busy have no effect on the current frame.
REQ-016 SHALL ignore start while busy=1, with no queuing.
REQ-017 SHALL process slots in ascending index order, 0 to N_SPRITES-1.
REQ-018 SHALL emit exactly one pixel per cycle in ERASE and DRAW, stepping index k=0..12 through this fixed (dx,dy) table: (0,0) (0,+1) (-1,0) (-2,0) (-3,0) (-4,0) (-5,0) (-3,+1) (-3,-1) (-4,+2) (-4,-2) (-5,+3) (-5,-3).
REQ-019 SHALL use the stored previous anchor of slot i and colour=000 in ERASE; SHALL use the latched anchor and colour=draw_colour in DRAW.
REQ-020 SHALL compute x_out=(ax+dx) mod 256 and y_out=(ay+dy) mod 128.
REQ-021 SHALL evaluate bounds on the signed, unwrapped sum; plot=1 only if 0<=ax+dx<=X_MAX and 0<=ay+dy<=Y_MAX, else plot=0 for that cycle (clipped pixels still consume their cycle).
REQ-022 SHALL, when slot i finishes, set prev_x[i]/prev_y[i] to the latched anchor and prev_valid[i] to the latched active[i].
REQ-023 SHALL hold plot=0 in IDLE, SELECT and DONE.
REQ-024 SHALL produce frame length = N_SPRITES + 13*(number of erase passes + number of draw passes) + 1 cycles, measured from the first SELECT through DONE inclusive.
REQ-025 SHALL assert done for exactly the DONE cycle; busy SHALL fall in that same cycle.

Reset
REQ-026 SHALL, on reset (any time, including mid-frame), immediately force: state=IDLE, plot=0, busy=0, done=0, x_out=0, y_out=0, colour=0, and all prev_valid=0.
REQ-027 SHALL, after reset, skip the erase pass for every slot in the first frame.

Verification
REQ-028 Fresh after reset, N=2, active=01, slot0=(10,20), colour=111, start -> SELECT; 13 DRAW pixels (10,20),(10,21),(9,20)...(5,17), all plot=1, colour=111; SELECT for slot1; done in cycle 16; busy high for cycles 1-15.
REQ-029 Second frame, slot0 moved to (11,20) -> 13 ERASE pixels at old (10,20)-based positions with colour=000, then 13 DRAW pixels at (11,20); frame length 2+26+1=29 cycles.
REQ-030 Clipping, slot0=(2,1) -> pixels with dx<=-3 or dy<=-2 give plot=0 (e.g. k=4 x_out=255); y_out wraps for the k=12 pixel; total cycle count unchanged.
REQ-031 Deactivate slot0 (active=00) after it was drawn -> erase pass only (13 cycles, colour=000); prev_valid[0]=0; the following frame lasts 3 cycles.
REQ-032 Start pulsed during DRAW, and pos_x changed mid-frame -> no restart, the pixel stream is unchanged, and there is exactly one done.
REQ-033 Reset asserted at DRAW k=6 -> plot=0 and busy=0 without waiting for a clock edge; the next frame draws with no erase pass.
